// File: rtl/nettlp_cmd_rx.sv
// NetTLP command receiver: parses 2-beat command packets from a 64-bit
// AXI-Stream, validates magic/opcode, and pushes one 96-bit command word
// into the command FIFO. Malformed packets are drained and counted.
module nettlp_cmd_rx #(
    parameter logic [15:0] MAGIC = 16'h4E54,
    parameter int          CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [63:0]      s_tdata,
    input  logic             s_tvalid,
    input  logic             s_tlast,
    output logic             s_tready,
    output logic             fifo_cmd_wr_en,
    input  logic             fifo_cmd_full,
    output logic [95:0]      fifo_cmd_din,
    output logic [CNT_W-1:0] pkt_ok_cnt,
    output logic [CNT_W-1:0] pkt_drop_cnt
);

    typedef enum logic [1:0] {HDR, BODY, PUSH, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [95:0]        din_q, din_d;
    logic [CNT_W-1:0]   ok_q, ok_d;
    logic [CNT_W-1:0]   drop_q, drop_d;
    logic               ready;
    logic               push;
    logic               hdr_good;
    logic [7:0]         opcode;

    assign opcode   = s_tdata[47:40];
    assign hdr_good = (s_tdata[63:48] == MAGIC) &&
                      (opcode == 8'h01 || opcode == 8'h02);

    // Next-state, datapath latching and counter updates
    always_comb begin
        state_d = state_q;
        din_d   = din_q;
        ok_d    = ok_q;
        drop_d  = drop_q;
        ready   = 1'b0;
        push    = 1'b0;
        case (state_q)
            HDR: begin
                ready = 1'b1;
                if (s_tvalid) begin
                    din_d[95:64] = {opcode, s_tdata[39:24], 8'h00};
                    if (hdr_good && !s_tlast) begin
                        state_d = BODY;
                    end else if (s_tlast) begin
                        // bad or short single-beat packet: already complete
                        drop_d = drop_q + CNT_W'(1);
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            BODY: begin
                ready = 1'b1;
                if (s_tvalid) begin
                    din_d[63:0] = s_tdata;
                    state_d     = s_tlast ? PUSH : DRAIN;
                end
            end
            PUSH: begin
                // din is frozen here; only the FIFO's full flag gates the push
                if (!fifo_cmd_full) begin
                    push    = 1'b1;
                    ok_d    = ok_q + CNT_W'(1);
                    state_d = HDR;
                end
            end
            DRAIN: begin
                ready = 1'b1;
                if (s_tvalid && s_tlast) begin
                    drop_d  = drop_q + CNT_W'(1);
                    state_d = HDR;
                end
            end
            default: state_d = HDR;
        endcase
    end

    // Handshake outputs are held low while reset is asserted
    assign s_tready       = rst && ready;
    assign fifo_cmd_wr_en = rst && push;
    assign fifo_cmd_din   = din_q;
    assign pkt_ok_cnt     = ok_q;
    assign pkt_drop_cnt   = drop_q;

    // State, command word and statistics registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HDR;
            din_q   <= '0;
            ok_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            din_q   <= din_d;
            ok_q    <= ok_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_nettlp_cmd_rx.sv
// Testbench for nettlp_cmd_rx: directed vector table, hand-written
// full/reset sequences, and random traffic against a packet-level model.
module tb_nettlp_cmd_rx;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [63:0] s_tdata = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tlast = 1'b0;
    logic        s_tready;
    logic        fifo_cmd_wr_en;
    logic        fifo_cmd_full = 1'b0;
    logic [95:0] fifo_cmd_din;
    logic [31:0] pkt_ok_cnt;
    logic [31:0] pkt_drop_cnt;

    int n_cmp = 0;
    int n_err = 0;

    nettlp_cmd_rx #(.MAGIC(16'h4E54), .CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .fifo_cmd_wr_en(fifo_cmd_wr_en), .fifo_cmd_full(fifo_cmd_full),
        .fifo_cmd_din(fifo_cmd_din),
        .pkt_ok_cnt(pkt_ok_cnt), .pkt_drop_cnt(pkt_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- packet-level reference model ----------------
    // A packet is forwarded iff it is exactly two beats and its first beat
    // carries the magic and a read/write opcode; otherwise it is dropped
    // when its last beat arrives. A forwarded packet blocks input until
    // the FIFO has room.
    int          m_n    = 0;
    logic [63:0] m_hdr  = '0;
    logic [63:0] m_b1   = '0;
    bit          m_pend = 0;
    logic [95:0] m_din  = '0;
    logic [31:0] m_ok   = '0;
    logic [31:0] m_drop = '0;

    always @(posedge clk) begin
        if (!rst) begin
            m_n = 0; m_pend = 0; m_ok = '0; m_drop = '0;
        end else if (m_pend) begin
            if (!fifo_cmd_full) begin
                m_pend = 0;
                m_ok   = m_ok + 1;
            end
        end else if (s_tvalid) begin
            if (m_n == 0) m_hdr = s_tdata;
            else if (m_n == 1) m_b1 = s_tdata;
            m_n++;
            if (s_tlast) begin
                if (m_n == 2 && m_hdr[63:48] == 16'h4E54 &&
                    (m_hdr[47:40] == 8'h01 || m_hdr[47:40] == 8'h02)) begin
                    m_pend = 1;
                    m_din  = {m_hdr[47:24], 8'h00, m_b1};
                end else begin
                    m_drop = m_drop + 1;
                end
                m_n = 0;
            end
        end
    end

    // Compare every cycle against the model, away from the active edge
    always @(negedge clk) begin
        chk("m_tready", 96'(s_tready), 96'(rst && !m_pend));
        chk("m_wr_en", 96'(fifo_cmd_wr_en), 96'(rst && m_pend && !fifo_cmd_full));
        chk("m_ok_cnt", 96'(pkt_ok_cnt), 96'(m_ok));
        chk("m_drop_cnt", 96'(pkt_drop_cnt), 96'(m_drop));
        if (m_pend) chk("m_din", fifo_cmd_din, m_din);
    end

    // ---------------- stimulus ----------------
    task automatic apply(input logic r, input logic v, input logic [63:0] d,
                         input logic l, input logic f);
        @(posedge clk);
        #1;
        rst = r; s_tvalid = v; s_tdata = d; s_tlast = l; fifo_cmd_full = f;
    endtask

    typedef struct {
        logic        v;
        logic [63:0] d;
        logic        l;
        logic        rdy;
        logic        wr;
        logic [31:0] ok;
        logic [31:0] dr;
        logic        cd;
        logic [95:0] din;
    } vec_t;

    vec_t tq[$];

    task automatic addv(input logic v, input logic [63:0] d, input logic l,
                        input logic rdy, input logic wr, input logic [31:0] ok,
                        input logic [31:0] dr, input logic cd, input logic [95:0] din);
        vec_t e;
        e.v = v; e.d = d; e.l = l; e.rdy = rdy; e.wr = wr;
        e.ok = ok; e.dr = dr; e.cd = cd; e.din = din;
        tq.push_back(e);
    endtask

    function automatic logic [63:0] rnd_beat();
        logic [7:0]  op;
        logic [15:0] mg;
        int s;
        s  = int'($urandom_range(0, 9));
        op = (s < 4) ? 8'h01 : (s < 8) ? 8'h02 : (s == 8) ? 8'h07 : 8'($urandom);
        mg = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'h4E54;
        return {mg, op, 16'($urandom), 24'($urandom)};
    endfunction

    initial begin
        // reset state
        apply(0, 0, '0, 0, 0);
        apply(0, 0, '0, 0, 0);
        @(negedge clk);
        chk("rst_tready", 96'(s_tready), 96'(0));
        chk("rst_wr_en", 96'(fifo_cmd_wr_en), 96'(0));
        chk("rst_din", fifo_cmd_din, 96'(0));
        chk("rst_ok", 96'(pkt_ok_cnt), 96'(0));
        chk("rst_drop", 96'(pkt_drop_cnt), 96'(0));
        apply(1, 0, '0, 0, 0);
        @(negedge clk);
        chk("tready_after_rst", 96'(s_tready), 96'(1));

        // directed table: valid write, bad magic, bad opcode, short, read, long, write
        addv(0, 64'h0, 0,                    1, 0, 0, 0, 0, '0);
        addv(1, 64'h4E54_02_00AB_000000, 0,  1, 0, 0, 0, 0, '0);
        addv(1, 64'h0000_1000_DEAD_BEEF, 1,  1, 0, 0, 0, 0, '0);
        addv(0, 64'h0, 0,                    0, 1, 0, 0, 1, 96'h02_00AB_00_00001000_DEADBEEF);
        addv(0, 64'h0, 0,                    1, 0, 1, 0, 0, '0);
        addv(1, 64'h1234_02_00AB_000000, 0,  1, 0, 1, 0, 0, '0);
        addv(1, 64'h1111_2222_3333_4444, 0,  1, 0, 1, 0, 0, '0);
        addv(1, 64'h5555_6666_7777_8888, 0,  1, 0, 1, 0, 0, '0);
        addv(1, 64'h9999_AAAA_BBBB_CCCC, 1,  1, 0, 1, 0, 0, '0);
        addv(0, 64'h0, 0,                    1, 0, 1, 1, 0, '0);
        addv(1, 64'h4E54_07_0001_000000, 0,  1, 0, 1, 1, 0, '0);
        addv(1, 64'h0000_0000_0000_0000, 1,  1, 0, 1, 1, 0, '0);
        addv(1, 64'h4E54_01_0002_000000, 1,  1, 0, 1, 2, 0, '0);
        addv(1, 64'h4E54_01_0055_000000, 0,  1, 0, 1, 3, 0, '0);
        addv(1, 64'h0000_2000_0000_0000, 1,  1, 0, 1, 3, 0, '0);
        addv(0, 64'h0, 0,                    0, 1, 1, 3, 1, 96'h01_0055_00_00002000_00000000);
        addv(1, 64'h4E54_02_0077_000000, 0,  1, 0, 2, 3, 0, '0);
        addv(1, 64'h0000_4000_0000_0001, 0,  1, 0, 2, 3, 0, '0);
        addv(1, 64'h0000_4000_0000_0002, 1,  1, 0, 2, 3, 0, '0);
        addv(1, 64'h4E54_02_0099_000000, 0,  1, 0, 2, 4, 0, '0);
        addv(1, 64'h0000_3000_1234_5678, 1,  1, 0, 2, 4, 0, '0);
        addv(0, 64'h0, 0,                    0, 1, 2, 4, 1, 96'h02_0099_00_00003000_12345678);
        addv(0, 64'h0, 0,                    1, 0, 3, 4, 0, '0);
        for (int i = 0; i < tq.size(); i++) begin
            apply(1, tq[i].v, tq[i].d, tq[i].l, 0);
            @(negedge clk);
            chk($sformatf("tbl%0d_tready", i), 96'(s_tready), 96'(tq[i].rdy));
            chk($sformatf("tbl%0d_wr_en", i), 96'(fifo_cmd_wr_en), 96'(tq[i].wr));
            chk($sformatf("tbl%0d_ok", i), 96'(pkt_ok_cnt), 96'(tq[i].ok));
            chk($sformatf("tbl%0d_drop", i), 96'(pkt_drop_cnt), 96'(tq[i].dr));
            if (tq[i].cd) chk($sformatf("tbl%0d_din", i), fifo_cmd_din, tq[i].din);
        end

        // FIFO full for 10 cycles after beat1
        apply(1, 1, 64'h4E54_01_0BEE_000000, 0, 0);
        apply(1, 1, 64'hCAFE_0000_0000_0042, 1, 1);
        for (int i = 0; i < 10; i++) begin
            apply(1, 1, 64'h4E54_02_0001_000000, 0, 1);
            @(negedge clk);
            chk($sformatf("full%0d_tready", i), 96'(s_tready), 96'(0));
            chk($sformatf("full%0d_wr_en", i), 96'(fifo_cmd_wr_en), 96'(0));
            chk($sformatf("full%0d_din", i), fifo_cmd_din, 96'h01_0BEE_00_CAFE0000_00000042);
        end
        apply(1, 0, '0, 0, 0);
        @(negedge clk);
        chk("full_release_wr_en", 96'(fifo_cmd_wr_en), 96'(1));
        chk("full_release_din", fifo_cmd_din, 96'h01_0BEE_00_CAFE0000_00000042);
        apply(1, 1, 64'h4E54_02_0123_000000, 0, 0);
        apply(1, 1, 64'h0000_5000_0000_0005, 1, 0);
        apply(1, 0, '0, 0, 0);
        @(negedge clk);
        chk("after_full_wr_en", 96'(fifo_cmd_wr_en), 96'(1));
        chk("after_full_din", fifo_cmd_din, 96'h02_0123_00_00005000_00000005);

        // reset while in BODY
        apply(1, 0, '0, 0, 0);
        apply(1, 1, 64'h4E54_02_00CC_000000, 0, 0);
        apply(0, 0, '0, 0, 0);
        @(negedge clk);
        chk("midrst_tready", 96'(s_tready), 96'(0));
        chk("midrst_wr_en", 96'(fifo_cmd_wr_en), 96'(0));
        apply(0, 0, '0, 0, 0);
        @(negedge clk);
        chk("midrst_ok", 96'(pkt_ok_cnt), 96'(0));
        chk("midrst_drop", 96'(pkt_drop_cnt), 96'(0));
        chk("midrst_din", fifo_cmd_din, 96'(0));
        // leftover beat is reparsed as a header with bad magic
        apply(1, 1, 64'h0000_1000_DEAD_BEEF, 1, 0);
        apply(1, 1, 64'h4E54_02_00DD_000000, 0, 0);
        apply(1, 1, 64'h0000_6000_0000_0006, 1, 0);
        apply(1, 0, '0, 0, 0);
        @(negedge clk);
        chk("postrst_wr_en", 96'(fifo_cmd_wr_en), 96'(1));
        chk("postrst_drop", 96'(pkt_drop_cnt), 96'(1));
        apply(1, 0, '0, 0, 0);
        @(negedge clk);
        chk("postrst_ok", 96'(pkt_ok_cnt), 96'(1));

        // random traffic, checked by the model
        for (int i = 0; i < 4000; i++) begin
            apply(($urandom_range(0, 299) != 0),
                  ($urandom_range(0, 3) != 0),
                  rnd_beat(),
                  ($urandom_range(0, 1) == 1),
                  ($urandom_range(0, 2) == 0));
        end
        apply(1, 0, '0, 0, 0);
        apply(1, 0, '0, 0, 0);
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
